// File: rtl/pipe_pkg.sv
// Shared definitions for the CPU pipeline-stage registers: state encoding,
// stage bundle widths, field offsets and bubble kill masks.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  // EX/MEM bundle, MSB first: MemRead, MemWrite, WriteData, WriteAddr,
  // MemtoReg, RegWrite, ALU_out, PC_Plus_4
  localparam int EXMEM_W            = 106;
  localparam int EXMEM_PC4_LSB      = 0;
  localparam int EXMEM_ALU_LSB      = 32;
  localparam int EXMEM_REGWRITE     = 64;
  localparam int EXMEM_MEMTOREG_LSB = 65;
  localparam int EXMEM_WADDR_LSB    = 67;
  localparam int EXMEM_WDATA_LSB    = 72;
  localparam int EXMEM_MEMWRITE     = 104;
  localparam int EXMEM_MEMREAD      = 105;

  localparam logic [EXMEM_W-1:0] EXMEM_KILL_MASK =
    (106'd1 << EXMEM_REGWRITE) | (106'd1 << EXMEM_MEMWRITE) | (106'd1 << EXMEM_MEMREAD);

endpackage

// File: rtl/pipe_skid_slot.sv
// One valid+data holding register; clear wins over load so a flush always
// leaves the slot empty.
module pipe_skid_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Reusable pipeline-stage register with valid/ready handshake, flush with
// bubble masking and an optional 2-entry skid buffer.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int              DATA_W    = 106,
  parameter logic [DATA_W-1:0] KILL_MASK = {DATA_W{1'b0}},
  parameter bit              SKID      = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  state_t            state_q, state_d;
  logic              ready_q;
  logic              in_fire, out_fire;
  logic              main_load, main_clear, skid_load, skid_clear;
  logic [DATA_W-1:0] main_src, main_data, skid_data;
  logic              main_valid, skid_valid;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = main_valid & out_ready;

  always_comb begin
    state_d    = state_q;
    main_load  = 1'b0;
    main_clear = 1'b0;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    main_src   = in_data;
    if (flush) begin
      state_d    = EMPTY;
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_load = 1'b1;
            state_d   = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_load = 1'b1;
          end else if (in_fire) begin
            skid_load = 1'b1;
            state_d   = TWO;
          end else if (out_fire) begin
            main_clear = 1'b1;
            state_d    = EMPTY;
          end
        end
        TWO: begin
          if (out_fire) begin
            main_src   = skid_data;
            main_load  = 1'b1;
            skid_clear = 1'b1;
            state_d    = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // ready_q stays low through reset and one edge beyond; with a skid it is the
  // whole registered in_ready, otherwise it only gates the combinational term.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= SKID ? (state_d != TWO) : 1'b1;
    end
  end

  assign in_ready = SKID ? ready_q : (ready_q & (~main_valid | out_ready));

  pipe_skid_slot #(.W(DATA_W)) u_main (
    .clk   (clk),
    .reset (reset),
    .load  (main_load),
    .clear (main_clear),
    .d     (main_src),
    .valid (main_valid),
    .q     (main_data)
  );

  generate
    if (SKID) begin : g_skid
      pipe_skid_slot #(.W(DATA_W)) u_skid (
        .clk   (clk),
        .reset (reset),
        .load  (skid_load),
        .clear (skid_clear),
        .d     (in_data),
        .valid (skid_valid),
        .q     (skid_data)
      );
    end else begin : g_noskid
      assign skid_valid = 1'b0;
      assign skid_data  = '0;
    end
  endgenerate

  assign out_valid = main_valid;
  assign out_data  = main_valid ? main_data : (main_data & ~KILL_MASK);
  assign occupancy = state_q;

  // Upstream must hold a refused payload; a flush releases that obligation.
  a_in_stable: assert property (@(posedge clk) disable iff (!reset)
    (in_valid && !in_ready && !flush) |=> (in_valid && $stable(in_data)));

  a_state_valid: assert property (@(posedge clk) disable iff (!reset)
    ((state_q == TWO) == skid_valid) && ((state_q != EMPTY) == main_valid));

endmodule
